// File: rtl/rggen_response_stage_pkg.sv
// rggen_response_stage_pkg: shared FSM state encoding and bus status codes
package rggen_response_stage_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;
endpackage

// File: rtl/rggen_mux.sv
// rggen_mux: one-hot AND-OR multiplexer over packed per-entry fields
module rggen_mux #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 2
) (
  input  logic [ENTRIES-1:0]       select,
  input  logic [ENTRIES*WIDTH-1:0] data,
  output logic [WIDTH-1:0]         out
);
  always_comb begin
    out = '0;
    for (int i = 0; i < ENTRIES; i++) out |= data[i*WIDTH+:WIDTH] & {WIDTH{select[i]}};
  end
endmodule

// File: rtl/rggen_response_stage.sv
// rggen_response_stage: strobes the decoded register, waits for ready and holds the muxed response
module rggen_response_stage
  import rggen_response_stage_pkg::*;
#(
  parameter int                      ENTRIES        = 2,
  parameter int                      DATA_WIDTH     = 32,
  parameter int                      STATUS_WIDTH   = 2,
  parameter logic [STATUS_WIDTH-1:0] ERROR_STATUS   = STATUS_WIDTH'(SLVERR),
  parameter int                      TIMEOUT_CYCLES = 0
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_request_valid,
  output logic                               o_request_ready,
  input  logic                               i_request_write,
  input  logic [ENTRIES-1:0]                 i_entry_hit,
  output logic                               o_entry_valid,
  output logic [ENTRIES-1:0]                 o_entry_select,
  input  logic [ENTRIES-1:0]                 i_entry_ready,
  input  logic [ENTRIES*STATUS_WIDTH-1:0]    i_entry_status,
  input  logic [ENTRIES*DATA_WIDTH-1:0]      i_entry_read_data,
  output logic                               o_response_valid,
  input  logic                               i_response_ready,
  output logic [STATUS_WIDTH-1:0]            o_response_status,
  output logic [DATA_WIDTH-1:0]              o_response_read_data
);
  localparam int CW    = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TLAST = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
  state_e                  state, state_d;
  logic [ENTRIES-1:0]      hit_q, hit_d, sel;
  logic                    write_q, write_d, expired;
  logic [CW-1:0]           count, count_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d, mux_status;
  logic [DATA_WIDTH-1:0]   data_q, data_d, mux_data;
  // only entries that were both decoded and report ready may drive the response
  assign sel     = hit_q & i_entry_ready;
  assign expired = TIMEOUT_CYCLES > 0 && count == CW'(TLAST);
  rggen_mux #(.WIDTH(STATUS_WIDTH), .ENTRIES(ENTRIES)) u_status_mux (
    .select(sel), .data(i_entry_status), .out(mux_status)
  );
  rggen_mux #(.WIDTH(DATA_WIDTH), .ENTRIES(ENTRIES)) u_data_mux (
    .select(sel), .data(i_entry_read_data), .out(mux_data)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      hit_q    <= '0;
      write_q  <= 1'b0;
      count    <= '0;
      status_q <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_d;
      hit_q    <= hit_d;
      write_q  <= write_d;
      count    <= count_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end
  always_comb begin
    state_d  = state;
    hit_d    = hit_q;
    write_d  = write_q;
    count_d  = count;
    status_d = status_q;
    data_d   = data_q;
    case (state)
      IDLE: if (i_request_valid) begin
        hit_d   = i_entry_hit;
        write_d = i_request_write;
        count_d = '0;
        if (i_entry_hit == '0) begin
          status_d = ERROR_STATUS;
          data_d   = '0;
          state_d  = RESPOND;
        end else state_d = ACCESS;
      end
      ACCESS: if (sel != '0) begin
        status_d = mux_status;
        data_d   = write_q ? '0 : mux_data;
        state_d  = RESPOND;
      end else if (expired) begin
        status_d = ERROR_STATUS;
        data_d   = '0;
        state_d  = RESPOND;
      end else count_d = count + CW'(count != '1);
      RESPOND: if (i_response_ready) begin
        hit_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign o_request_ready      = state == IDLE;
  assign o_entry_valid        = state == ACCESS;
  assign o_entry_select       = hit_q;
  assign o_response_valid     = state == RESPOND;
  assign o_response_status    = status_q;
  assign o_response_read_data = data_q;
endmodule

// File: tb/tb_rggen_response_stage.sv
// tb_rggen_response_stage: randomized scoreboard bench for the register response stage
module tb_rggen_response_stage;
  localparam int N = 4, DW = 32, SW = 2, TO = 8;
  localparam logic [SW-1:0] ERR = 2'b10;
  typedef struct packed {logic [SW-1:0] st; logic [DW-1:0] d;} rsp_t;
  logic clk = 1'b0, rst;
  logic req_valid, req_ready, req_write, entry_valid, rsp_valid, rsp_ready;
  logic [N-1:0] entry_hit, entry_select, entry_ready;
  logic [N*SW-1:0] entry_status;
  logic [N*DW-1:0] entry_data;
  logic [SW-1:0] rsp_status;
  logic [DW-1:0] rsp_data;
  int checks = 0, failures = 0;
  bit hold_rsp = 1'b1;
  rsp_t exp_q[$];
  rggen_response_stage #(
    .ENTRIES(N), .DATA_WIDTH(DW), .STATUS_WIDTH(SW), .ERROR_STATUS(ERR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(req_valid), .o_request_ready(req_ready), .i_request_write(req_write),
    .i_entry_hit(entry_hit), .o_entry_valid(entry_valid), .o_entry_select(entry_select),
    .i_entry_ready(entry_ready), .i_entry_status(entry_status), .i_entry_read_data(entry_data),
    .o_response_valid(rsp_valid), .i_response_ready(rsp_ready),
    .o_response_status(rsp_status), .o_response_read_data(rsp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_entry_valid"}, entry_valid, 0);
    chk({tag, "_entry_select"}, entry_select, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
  endtask
  // host response acceptance: random back-pressure unless held off
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 rsp_ready = !hold_rsp && $urandom_range(0, 3) != 0;
    end
  end
  // monitor: pops one expectation per accepted response, checks hold stability
  initial begin
    rsp_t prev, e;
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rsp_blocks_request", req_ready, 0);
        if (pend) chk("rsp_stable", {rsp_status, rsp_data}, prev);
        if (rsp_ready) begin
          pend = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=%0h required=none", {rsp_status, rsp_data});
          end else begin
            e = exp_q.pop_front();
            chk("rsp_status", rsp_status, e.st);
            chk("rsp_data", rsp_data, e.d);
          end
        end else begin
          pend = 1'b1;
          prev = {rsp_status, rsp_data};
        end
      end else pend = 1'b0;
    end
  end
  // one host access; delay is the ACCESS cycle index at which the hit entry raises ready
  task automatic txn(input logic [N-1:0] hit, input bit wr, input int delay);
    logic [N*SW-1:0] st;
    logic [N*DW-1:0] dt;
    rsp_t e;
    int idx = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      st[i*SW+:SW] = SW'($urandom);
      dt[i*DW+:DW] = $urandom;
      if (hit[i]) idx = i;
    end
    entry_status = st;
    entry_data   = dt;
    entry_ready  = '0;
    req_write    = wr;
    entry_hit    = hit;
    req_valid    = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (req_ready) break;
      if (t == 200) begin
        $display("FAIL accept_timeout actual=req_ready=0 required=1");
        $fatal(1, "request never accepted");
      end
    end
    if (hit == '0 || delay >= TO) e = '{st: ERR, d: '0};
    else e = '{st: st[idx*SW+:SW], d: wr ? '0 : dt[idx*DW+:DW]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    entry_hit = N'($urandom);
    if (hit != '0) begin
      for (int k = 0; k < TO; k++) begin
        entry_ready = N'($urandom) & ~hit;
        if (k == delay) entry_ready = entry_ready | hit;
        @(negedge clk);
        chk("entry_valid", entry_valid, 1);
        chk("entry_select", entry_select, hit);
        chk("req_ready_access", req_ready, 0);
        @(posedge clk);
        #1 entry_ready = '0;
        if (k == delay) break;
      end
    end
    @(negedge clk);
    chk("entry_valid_end", entry_valid, 0);
    chk("rsp_valid_latency", rsp_valid, 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
  endtask
  initial begin
    req_valid = 0; req_write = 0; entry_hit = '0; entry_ready = '0;
    entry_status = '0; entry_data = '0;
    rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_rsp = 1'b0;
    txn(4'b0100, 1'b0, 2);
    hold_rsp = 1'b1;
    txn(4'b0001, 1'b1, 0);
    repeat (5) @(posedge clk);
    hold_rsp = 1'b0;
    txn(4'b0000, 1'b0, 0);
    txn(4'b1000, 1'b0, TO + 3);
    txn(4'b1000, 1'b0, TO - 1);
    txn(4'b1000, 1'b0, 3);
    drain();
    hold_rsp = 1'b1;
    @(posedge clk);
    #1 entry_hit = 4'b0010; req_valid = 1'b1; entry_ready = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("rst_access");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 entry_hit = 4'b0000; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("respond_before_rst", {rsp_valid, rsp_status}, {1'b1, ERR});
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_respond");
    @(posedge clk);
    #1 rst = 1'b0;
    hold_rsp = 1'b0;
    txn(4'b0010, 1'b0, 1);
    for (int n = 0; n < 150; n++) begin
      int r = $urandom_range(0, 9);
      int d = r < 7 ? $urandom_range(0, 3) : r == 7 ? TO - 1 : r == 8 ? TO : TO + 5;
      logic [N-1:0] h = $urandom_range(0, 4) == 0 ? '0 : N'(1) << $urandom_range(0, N - 1);
      txn(h, 1'($urandom), d);
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
